// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: returns 32-bit words for word-aligned fetch addresses, in accept order.
// Latency: LATENCY cycles from accept to output-buffer write; the head is visible the cycle after.
// Backpressure: credit count caps in-flight plus buffered fetches at LATENCY+1; requestReady drops at the cap.

// Small synchronous FIFO with registered storage; output data reads as zero while empty.
// Latency: a written entry is visible at the head the cycle after the write.
// Backpressure: none internally; the producer must never write while full (asserted).
module instr_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    assign full   = (cnt == FULL_CNT);
    assign rd_vld = (cnt != '0);
    assign rd_dat = rd_vld ? store[rd_ptr] : '0;
    assign wr_en  = wr_vld & ~full & ~clr;
    assign rd_en  = rd_rdy & rd_vld & ~clr;

    // Entry storage; not reset because rd_dat is gated by occupancy.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            store[wr_ptr] <= wr_dat;
        end
    end

    // Pointers and occupancy; clear empties the buffer in a single edge.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            cnt <= cnt + (PW+1)'(wr_en) - (PW+1)'(rd_en);
        end
    end

    // A write into a full buffer means the upstream credit limit was broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst || clr) wr_vld |-> !full)
        else $error("instr_resp_fifo: write into full buffer");
endmodule

module instr_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] readAddress,
    input  logic        requestValid,
    output logic        requestReady,
    input  logic        flush,
    input  logic        loadEnable,
    input  logic [31:0] loadAddress,
    input  logic [31:0] loadData,
    output logic [31:0] instruction,
    output logic [31:0] instructionAddress,
    output logic        fault,
    output logic        instructionValid,
    input  logic        instructionReady
);
    localparam int            AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int            CW      = $clog2(LATENCY + 2);
    localparam logic [CW-1:0] MAX_CNT = CW'(LATENCY + 1);
    localparam logic [29:0]   DEPTH_W = 30'(DEPTH_WORDS);
    localparam int            EW      = 65;

    typedef struct packed {
        logic        vld;
        logic [31:0] addr;
        logic [31:0] dat;
        logic        fault;
    } stage_t;

    logic [31:0]   mem [DEPTH_WORDS];
    stage_t        pipe [LATENCY];
    stage_t        stage_in;
    logic [CW-1:0] count;
    logic          accept;
    logic          pop;
    logic          rd_fault;
    logic [31:0]   rd_word;
    logic          ld_ok;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] ld_idx;
    logic [EW-1:0] head_dat;
    logic          unused_bits;

    // Ready is a pure function of flush, load and the registered credit count.
    assign requestReady = !reset && !flush && !loadEnable && (count < MAX_CNT);
    assign accept       = requestValid & requestReady;
    assign pop          = instructionValid & instructionReady;

    assign rd_idx   = readAddress[AW+1:2];
    assign ld_idx   = loadAddress[AW+1:2];
    assign rd_fault = (readAddress[1:0] != 2'b00) || (readAddress[31:2] >= DEPTH_W);
    assign ld_ok    = (loadAddress[31:2] < DEPTH_W);
    assign rd_word  = rd_fault ? 32'h0 : mem[rd_idx];
    assign stage_in = {accept, readAddress, rd_word, rd_fault};

    // Low address bits of the load port are don't-care.
    assign unused_bits = &{1'b0, loadAddress[1:0]};

    // Program-load write port; out-of-range writes are dropped, contents survive reset.
    always_ff @(posedge clock) begin
        if (loadEnable && ld_ok) begin
            mem[ld_idx] <= loadData;
        end
    end

    // Read pipeline shifts every cycle; backpressure is absorbed by the output buffer.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= stage_in;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Credit count of in-flight plus buffered fetches.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(accept) - CW'(pop);
        end
    end

    instr_resp_fifo #(
        .WIDTH (EW),
        .DEPTH (LATENCY + 1)
    ) u_out_buf (
        .clk    (clock),
        .rst    (reset),
        .clr    (flush),
        .wr_vld (pipe[LATENCY-1].vld),
        .wr_dat ({pipe[LATENCY-1].addr, pipe[LATENCY-1].dat, pipe[LATENCY-1].fault}),
        .rd_rdy (instructionReady),
        .rd_vld (instructionValid),
        .rd_dat (head_dat)
    );

    assign {instructionAddress, instruction, fault} = head_dat;
endmodule
